hash_probe_sequencer: RTL and testbench
=======================================

// Module: hash_probe_sequencer
// PURPOSE
// Front-end sequencer for the 8-way tabulation hash unit. Accepts one 45-bit
// virtual page number (VPN) per request, drives the hash unit with that VPN for
// hash IDs 0..NUM_HASHES-1 in turn, and captures each registered 32-bit hash.
// Each hash is truncated to a bucket index and streamed downstream as a tagged
// candidate, so the page-table probe logic can check every candidate bucket.
// PARAMETERS
// NUM_HASHES    8   hash functions probed per VPN (legal range 1..8)
// INDEX_BITS    12  bucket index width; index = hash[INDEX_BITS-1:0] (legal range 1..32)
// HASH_LATENCY  1   cycles from driving hash_vpn/hash_id to a valid hash_in (1..4)
// PORTS
// clk          in   1           clock; all state on the rising edge
// rst_n        in   1           asynchronous active-low reset
// req_valid    in   1           request VPN valid
// req_vpn      in   45          VPN to hash
// req_ready    out  1           sequencer idle; request accepted when req_valid&req_ready
// hash_vpn     out  45          VPN to hash unit (latched copy of req_vpn)
// hash_id      out  3           hash function select to hash unit
// hash_in      in   32          registered hash result from hash unit
// cand_valid   out  1           candidate output valid
// cand_ready   in   1           downstream accepts candidate
// cand_index   out  INDEX_BITS  bucket index = hash[INDEX_BITS-1:0]
// cand_id      out  3           hash ID that produced cand_index
// cand_last    out  1           candidate is the last one (id == NUM_HASHES-1) for this VPN
// busy         out  1           high in every state except IDLE
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, req_ready=1, cand_valid=0,
//   cand_index=0, cand_id=0, cand_last=0, hash_vpn=0, hash_id=0, busy=0,
//   wait counter=0. Assertion mid-request aborts it; no partial candidates follow.
// - FSM states: IDLE, ISSUE, WAIT, EMIT.
// - IDLE: req_ready=1. On req_valid: latch req_vpn into hash_vpn, hash_id<=0,
//   go to ISSUE. req_ready=0 in every other state; no request is queued.
// - ISSUE (1 cycle): hash_vpn/hash_id held stable, driving the hash unit; wait
//   counter<=HASH_LATENCY-1; go to WAIT.
// - WAIT: if counter==0, register cand_index<=hash_in[INDEX_BITS-1:0],
//   cand_id<=hash_id, cand_last<=(hash_id==NUM_HASHES-1), cand_valid<=1, go to
//   EMIT; otherwise decrement the counter. hash_vpn/hash_id stay stable
//   throughout WAIT.
// - EMIT: hold cand_* stable while cand_valid=1 and cand_ready=0 (no drop, no
//   change). On cand_ready: cand_valid<=0. If cand_last, go to IDLE; otherwise
//   hash_id<=hash_id+1 and go to ISSUE.
// - Timing with HASH_LATENCY=1: accept at edge T. ISSUE during T..T+1, WAIT
//   during T+1..T+2, first cand_valid at T+2. Each candidate takes 3 cycles
//   when cand_ready is held high. NUM_HASHES=8 gives 24 cycles from acceptance
//   to the last handshake; req_ready returns on the following cycle.
// - Width rules:
//   * hash_id is a 3-bit register and never passes NUM_HASHES-1, so it never
//     wraps.
//   * INDEX_BITS=32 passes hash_in through unmodified.
// - hash_vpn changes only on request acceptance.
// TESTING
// - Reset, then req_vpn=45'h1ABCDE, a stub hash returning {29'h0,hash_id}^32'hA5A5_0000,
//   cand_ready=1 -> 8 candidates, cand_id 0..7, cand_index=12'h000..12'h007,
//   cand_last only on id 7; req_ready=1 again 25 cycles after acceptance.
// - cand_ready low for 5 cycles on id 3 -> cand_index/cand_id stay constant,
//   hash_id stays 3, no candidate lost or duplicated.
// - HASH_LATENCY=3, stub hash unit with a 3-stage delay -> each cand_index
//   matches the hash for its own id (no off-by-one). Per-candidate period = 5 cycles.
// - NUM_HASHES=1 -> one candidate, cand_id=0, cand_last=1, then IDLE.
// - req_valid held high during busy -> no second acceptance until IDLE. Two
//   back-to-back VPNs yield two complete, ordered 8-candidate bursts.
// - rst_n pulsed low during WAIT of id 5 -> outputs at reset values immediately.
//   After release, the next request starts at cand_id 0.

Source files
------------

// File: rtl/hash_probe_sequencer.sv
// ============================================================================
// hash_probe_sequencer : drives the hash unit for each hash ID of one VPN and
// streams the truncated bucket indices downstream as tagged candidates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hash_probe_sequencer #(
  parameter int NUM_HASHES   = 8,
  parameter int INDEX_BITS   = 12,
  parameter int HASH_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [44:0]           req_vpn,
  output logic                  req_ready,
  output logic [44:0]           hash_vpn,
  output logic [2:0]            hash_id,
  input  logic [31:0]           hash_in,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic [INDEX_BITS-1:0] cand_index,
  output logic [2:0]            cand_id,
  output logic                  cand_last,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  localparam logic [2:0] LAST_ID   = 3'(NUM_HASHES - 1);
  localparam logic [1:0] WAIT_INIT = 2'(HASH_LATENCY - 1);

  logic [1:0] r_state;
  logic [1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 2'd0;
      hash_vpn   <= 45'd0;
      hash_id    <= 3'd0;
      cand_valid <= 1'b0;
      cand_index <= '0;
      cand_id    <= 3'd0;
      cand_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            hash_vpn <= req_vpn;
            hash_id  <= 3'd0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= WAIT_INIT;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            cand_index <= hash_in[INDEX_BITS-1:0];
            cand_id    <= hash_id;
            cand_last  <= (hash_id == LAST_ID);
            cand_valid <= 1'b1;
            r_state    <= S_EMIT;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        S_EMIT: begin
          // Candidate fields are held untouched until the downstream handshake.
          if (cand_ready) begin
            cand_valid <= 1'b0;
            if (cand_last) begin
              r_state <= S_IDLE;
            end else begin
              hash_id <= hash_id + 3'd1;
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  generate
    if (INDEX_BITS < 32) begin : g_unused_hash_bits
      logic unused_hash_bits;
      assign unused_hash_bits = ^hash_in[31:INDEX_BITS];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_hash_probe_sequencer.sv
// ============================================================================
// tb_hash_probe_sequencer : scoreboard bench for three sequencer configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hash_probe_sequencer;

  typedef struct packed {
    logic [44:0] vpn;
    logic [2:0]  id;
    logic [31:0] idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 8 hashes, 12-bit index, latency 1
  logic        rv_a = 0, cr_a = 1, rdy_a, cv_a, last_a, busy_a;
  logic [44:0] vpn_a = '0, hvpn_a;
  logic [2:0]  hid_a, cid_a;
  logic [31:0] hash_a = '0;
  logic [11:0] idx_a;
  // DUT B: 8 hashes, 32-bit index, latency 3
  logic        rv_b = 0, cr_b = 1, rdy_b, cv_b, last_b, busy_b;
  logic [44:0] vpn_b = '0, hvpn_b;
  logic [2:0]  hid_b, cid_b;
  logic [31:0] hash_b = '0, pb1 = '0, pb2 = '0;
  logic [31:0] idx_b;
  // DUT C: 1 hash, 12-bit index, latency 1
  logic        rv_c = 0, cr_c = 1, rdy_c, cv_c, last_c, busy_c;
  logic [44:0] vpn_c = '0, hvpn_c;
  logic [2:0]  hid_c, cid_c;
  logic [31:0] hash_c = '0;
  logic [11:0] idx_c;

  hash_probe_sequencer #(.NUM_HASHES(8), .INDEX_BITS(12), .HASH_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_vpn(vpn_a), .req_ready(rdy_a),
    .hash_vpn(hvpn_a), .hash_id(hid_a), .hash_in(hash_a), .cand_valid(cv_a),
    .cand_ready(cr_a), .cand_index(idx_a), .cand_id(cid_a), .cand_last(last_a), .busy(busy_a));

  hash_probe_sequencer #(.NUM_HASHES(8), .INDEX_BITS(32), .HASH_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_vpn(vpn_b), .req_ready(rdy_b),
    .hash_vpn(hvpn_b), .hash_id(hid_b), .hash_in(hash_b), .cand_valid(cv_b),
    .cand_ready(cr_b), .cand_index(idx_b), .cand_id(cid_b), .cand_last(last_b), .busy(busy_b));

  hash_probe_sequencer #(.NUM_HASHES(1), .INDEX_BITS(12), .HASH_LATENCY(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_c), .req_vpn(vpn_c), .req_ready(rdy_c),
    .hash_vpn(hvpn_c), .hash_id(hid_c), .hash_in(hash_c), .cand_valid(cv_c),
    .cand_ready(cr_c), .cand_index(idx_c), .cand_id(cid_c), .cand_last(last_c), .busy(busy_c));

  function automatic logic [31:0] stub(input logic [2:0] id);
    return {29'h0, id} ^ 32'hA5A5_0000;
  endfunction

  // Stub hash units: one register for latency 1, three for latency 3
  always @(posedge clk) begin
    hash_a <= stub(hid_a);
    hash_c <= stub(hid_c);
    pb1    <= stub(hid_b);
    pb2    <= pb1;
    hash_b <= pb2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int acc_a = 0, acc_b = 0, acc_c = 0;
  int hs_a = 0, hs_b = 0, hs_c = 0;
  int last_hs_b = 0;

  // Inputs only change just after posedge, so rv&&ready at negedge means acceptance next edge
  always @(negedge clk) begin
    if (rst_n && rv_a && rdy_a) begin
      acc_a++;
      for (int i = 0; i < 8; i++)
        qa.push_back(exp_t'{vpn: vpn_a, id: 3'(i), idx: stub(3'(i)) & 32'hFFF, last: (i == 7)});
    end
    if (rst_n && rv_b && rdy_b) begin
      acc_b++;
      for (int i = 0; i < 8; i++)
        qb.push_back(exp_t'{vpn: vpn_b, id: 3'(i), idx: stub(3'(i)), last: (i == 7)});
    end
    if (rst_n && rv_c && rdy_c) begin
      acc_c++;
      qc.push_back(exp_t'{vpn: vpn_c, id: 3'd0, idx: stub(3'd0) & 32'hFFF, last: 1'b1});
    end
  end

  always @(negedge clk) begin
    if (rst_n && cv_a && cr_a) begin
      if (qa.size() == 0) check("a_extra_cand", 1, 0);
      else begin
        ea = qa.pop_front();
        check("a_id", cid_a, ea.id);
        check("a_idx", idx_a, ea.idx);
        check("a_last", last_a, ea.last);
        check("a_vpn", hvpn_a, ea.vpn);
      end
      hs_a++;
    end
    if (rst_n && cv_b && cr_b) begin
      if (qb.size() == 0) check("b_extra_cand", 1, 0);
      else begin
        eb = qb.pop_front();
        check("b_id", cid_b, eb.id);
        check("b_idx", idx_b, eb.idx);
        check("b_last", last_b, eb.last);
        check("b_vpn", hvpn_b, eb.vpn);
        if (eb.id != 3'd0) check("b_period", cyc - last_hs_b, 5);
      end
      last_hs_b = cyc;
      hs_b++;
    end
    if (rst_n && cv_c && cr_c) begin
      if (qc.size() == 0) check("c_extra_cand", 1, 0);
      else begin
        ec = qc.pop_front();
        check("c_id", cid_c, ec.id);
        check("c_idx", idx_c, ec.idx);
        check("c_last", last_c, ec.last);
        check("c_vpn", hvpn_c, ec.vpn);
      end
      hs_c++;
    end
  end

  function automatic int acc_of(input int w);
    return (w == 0) ? acc_a : (w == 1) ? acc_b : acc_c;
  endfunction

  function automatic bit idle_of(input int w);
    case (w)
      0:       return rdy_a && (qa.size() == 0);
      1:       return rdy_b && (qb.size() == 0);
      default: return rdy_c && (qc.size() == 0);
    endcase
  endfunction

  task automatic set_req(input int w, input logic v, input logic [44:0] vpn);
    case (w)
      0:       begin rv_a = v; vpn_a = vpn; end
      1:       begin rv_b = v; vpn_b = vpn; end
      default: begin rv_c = v; vpn_c = vpn; end
    endcase
  endtask

  // Returns just after the accepting posedge
  task automatic send(input int w, input logic [44:0] vpn);
    int prev;
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    prev = acc_of(w);
    set_req(w, 1'b1, vpn);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if (acc_of(w) != prev) ok = 1;
    end
    check("accept_seen", ok, 1);
    @(posedge clk); #1;
    set_req(w, 1'b0, vpn);
  endtask

  task automatic wait_idle(input int w);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (idle_of(w)) ok = 1;
    end
    check("burst_done", ok, 1);
  endtask

  task automatic check_reset_a();
    check("rst_req_ready", rdy_a, 1);
    check("rst_cand_valid", cv_a, 0);
    check("rst_cand_index", idx_a, 0);
    check("rst_cand_id", cid_a, 0);
    check("rst_cand_last", last_a, 0);
    check("rst_hash_vpn", hvpn_a, 0);
    check("rst_hash_id", hid_a, 0);
    check("rst_busy", busy_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k_ready, k_valid, prev;
    bit ok;
    logic [2:0] held_id;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic burst with acceptance-to-ready timing
    send(0, 45'h1ABCDE);
    k_ready = 0; k_valid = 0;
    for (k = 1; k <= 100 && k_ready == 0; k++) begin
      @(negedge clk);
      if (cv_a && k_valid == 0) k_valid = k;
      if (rdy_a) k_ready = k;
    end
    check("a_first_valid_cycle", k_valid, 3);
    check("a_ready_return_cycle", k_ready, 25);
    wait_idle(0);

    // Stall id 3 for five cycles
    send(0, 45'h1234_5678_9AB);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (busy_a && !cv_a && hid_a == 3'd3) ok = 1;
    end
    check("a_reach_id3", ok, 1);
    @(posedge clk); #1; cr_a = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cv_a) ok = 1;
    end
    check("a_stall_valid", ok, 1);
    repeat (5) begin
      check("a_stall_hold_valid", cv_a, 1);
      check("a_stall_hold_id", cid_a, 3);
      check("a_stall_hold_idx", idx_a, 12'h003);
      check("a_stall_hash_id", hid_a, 3);
      check("a_stall_busy", busy_a, 1);
      @(negedge clk);
    end
    @(posedge clk); #1; cr_a = 1'b1;
    wait_idle(0);

    // req_valid held across two back-to-back requests
    @(posedge clk); #1;
    prev = acc_a;
    rv_a = 1'b1; vpn_a = 45'h0AAA_5555_1111;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if (acc_a == prev + 1) ok = 1;
    end
    @(posedge clk); #1;
    vpn_a = 45'h1555_AAAA_2222;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if (acc_a == prev + 2) ok = 1;
    end
    @(posedge clk); #1;
    rv_a = 1'b0;
    wait_idle(0);
    check("a_held_valid_accepts", acc_a - prev, 2);

    // Latency-3 configuration with full-width index
    send(1, 45'h0F0F_0F0F_0F0);
    wait_idle(1);
    send(1, 45'h1010_2020_303);
    wait_idle(1);

    // Single-hash configuration
    send(2, 45'h1FFF_FFFF_FFFF);
    wait_idle(2);
    check("c_ready_after_one", rdy_c, 1);
    send(2, 45'h0000_0000_0001);
    wait_idle(2);

    // Abort mid-request while waiting on id 5
    send(0, 45'h0123_4567_89A);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (busy_a && !cv_a && hid_a == 3'd5) ok = 1;
    end
    check("a_reach_id5", ok, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_a();
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("a_no_partial", cv_a, 0);
    end
    send(0, 45'h1357_9BDF_024);
    wait_idle(0);

    check("a_handshakes", hs_a, 45);
    check("b_handshakes", hs_b, 16);
    check("c_handshakes", hs_c, 2);
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    check("c_queue_empty", qc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
